uart_baud_ctrl: RTL

Baud-rate controller that owns the divisor input of the UART clock generator. It supports two ways to set the divisor. Software can load it directly, and the new value is applied only while both TX and RX are idle. Alternatively, it can auto-detect the divisor by timing the first two bit cells of a 0x55 sync character on the RX line. It sits between the register interface and the UART clock generator/TX/RX blocks.

---
 rtl/uart_baud_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_baud_ctrl.sv
// UART baud-rate controller. It drives the clock-generator divisor in one of two ways:
// a software-loaded value that is applied only while TX and RX are idle, or an autobaud
// measurement taken from the first two bit cells of a 0x55 sync character.
module uart_baud_ctrl #(
  parameter int unsigned DIV_BITS    = 10,
  parameter int unsigned DEFAULT_DIV = 26,
  parameter int unsigned IDLE_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  input  logic                i_cfg_we,
  input  logic [DIV_BITS-1:0] i_cfg_div,
  input  logic                i_tx_busy,
  input  logic                i_rx_busy,
  input  logic                i_ab_start,
  input  logic                i_ab_abort,
  output logic [DIV_BITS-1:0] o_div,
  output logic                o_ab_busy,
  output logic                o_ab_done,
  output logic                o_ab_err
);

  localparam int unsigned CNT_BITS  = DIV_BITS + 4;
  localparam int unsigned IDLE_BITS = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StWaitFall,
    StMeasLow,
    StMeasHigh,
    StCheck,
    StApply,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [IDLE_BITS-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_BITS-1:0]   t0_q, t0_d, t1_q, t1_d;
  logic [DIV_BITS-1:0]   div_q, div_d, pend_div_q, pend_div_d;
  logic                  pend_q, pend_d;

  logic                  rx_fall;
  logic [CNT_BITS-1:0]   t_diff, t_tol;
  logic                  too_short, mismatch, apply_ok;
  logic [DIV_BITS-1:0]   ab_div;

  // Two-flop RX synchronizer plus a delayed copy for edge detection; all idle high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Measurement checks: cells must agree within T0/8, and the rounded divisor must be >= 1.
  always_comb begin
    t_diff    = (t0_q >= t1_q) ? (t0_q - t1_q) : (t1_q - t0_q);
    t_tol     = t0_q >> 3;
    mismatch  = (t_diff > t_tol);
    too_short = (t0_q < CNT_BITS'(24));
    ab_div    = DIV_BITS'((({1'b0, t0_q} + (CNT_BITS + 1)'(8)) >> 4) - (CNT_BITS + 1)'(1));
    apply_ok  = (state_q == StIdle) && pend_q && !i_tx_busy && !i_rx_busy;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (i_ab_start) state_d = StWaitIdle;
      StWaitIdle: begin
        if (rx_sync_q && (idle_cnt_q == IDLE_BITS'(IDLE_CYCLES - 1))) state_d = StWaitFall;
      end
      StWaitFall: if (rx_fall) state_d = StMeasLow;
      StMeasLow: begin
        if (rx_sync_q)          state_d = StMeasHigh;
        else if (t0_q == CntMax) state_d = StErr;
      end
      StMeasHigh: begin
        if (!rx_sync_q)          state_d = StCheck;
        else if (t1_q == CntMax) state_d = StErr;
      end
      StCheck:    state_d = (mismatch || too_short) ? StErr : StApply;
      StApply:    state_d = StIdle;
      StErr:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if ((state_q != StIdle) && i_ab_abort) state_d = StIdle;
  end

  // FSM outputs; a same-cycle abort suppresses the result pulses.
  always_comb begin
    o_ab_busy = (state_q != StIdle);
    o_ab_done = (state_q == StApply) && !i_ab_abort;
    o_ab_err  = (state_q == StErr) && !i_ab_abort;
  end

  // Datapath next-state: idle counter, bit-cell timers, pending write and divisor.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (apply_ok) begin
          div_d  = pend_div_q;
          pend_d = 1'b0;
        end
        // A write coinciding with an autobaud start is dropped.
        if (i_cfg_we && !i_ab_start) begin
          pend_div_d = i_cfg_div;
          pend_d     = 1'b1;
        end
      end
      StWaitIdle: idle_cnt_d = rx_sync_q ? (idle_cnt_q + IDLE_BITS'(1)) : '0;
      StWaitFall: if (rx_fall) t0_d = CNT_BITS'(1);
      StMeasLow: begin
        if (rx_sync_q)           t1_d = CNT_BITS'(1);
        else if (t0_q != CntMax) t0_d = t0_q + CNT_BITS'(1);
      end
      StMeasHigh: if (rx_sync_q && (t1_q != CntMax)) t1_d = t1_q + CNT_BITS'(1);
      StApply: begin
        if (!i_ab_abort) begin
          div_d  = ab_div;
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idle_cnt_q <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      div_q      <= DIV_BITS'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
    end
  end

  assign o_div = div_q;

endmodule
